// File: rtl/snake_speed_ctrl.sv
// rtl/snake_speed_ctrl.sv - game pace controller: drives the frequency divider and turns its output into game ticks
// Speed level rises with food eaten; IDLE/RUN/PAUSE/OVER states gate the divider and the tick.
module snake_speed_ctrl #(
    parameter logic [24:0] BASE_DIV        = 25'd12_500_000,
    parameter logic [24:0] STEP_DIV        = 25'd1_000_000,
    parameter logic [24:0] MIN_DIV         = 25'd2_500_000,
    parameter int          FOODS_PER_LEVEL = 4,
    parameter int          LEVEL_W         = 4
) (
    input  logic               clk_50M,
    input  logic               rst,
    input  logic               start,
    input  logic               pause_btn,
    input  logic               food_eaten,
    input  logic               game_over,
    input  logic               div_clk,
    output logic [24:0]        divisor,
    output logic               div_rst_n,
    output logic               tick,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int FW = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;
    localparam int W  = 25 + LEVEL_W + 1;

    localparam logic [FW-1:0]      FOOD_LAST = FW'(FOODS_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
    localparam logic [W-1:0]       BASE_W    = W'(BASE_DIV);
    localparam logic [W-1:0]       STEP_W    = W'(STEP_DIV);
    localparam logic [W-1:0]       MIN_W     = W'(MIN_DIV);

    logic [1:0]         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [FW-1:0]      food_q, food_d;
    logic [24:0]        divisor_q, divisor_d;
    logic               div_rst_n_q, div_rst_n_d;
    logic               tick_q, tick_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               s3_q, s3_d;
    logic [W-1:0]       prod;
    logic               new_game;
    logic               count_food;

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            food_q      <= '0;
            divisor_q   <= BASE_DIV;
            div_rst_n_q <= 1'b0;
            tick_q      <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            food_q      <= food_d;
            divisor_q   <= divisor_d;
            div_rst_n_q <= div_rst_n_d;
            tick_q      <= tick_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
        end
    end

    // game_over outranks pause_btn while running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (game_over)
                    state_d = ST_OVER;
                else if (pause_btn)
                    state_d = ST_PAUSE;
            end
            ST_IDLE, ST_OVER: begin
                if (start)
                    state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (pause_btn)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        new_game   = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
        count_food = (state_q == ST_RUN) && food_eaten && !game_over;
        level_d    = level_q;
        food_d     = food_q;
        if (new_game) begin
            level_d = '0;
            food_d  = '0;
        end else if (count_food) begin
            if (food_q == FOOD_LAST) begin
                food_d = '0;
                if (level_q != LEVEL_MAX)
                    level_d = level_q + 1'b1;
            end else begin
                food_d = food_q + 1'b1;
            end
        end

        // Compare in the wide domain so a large level clamps instead of wrapping
        prod = W'(level_q) * STEP_W;
        if (prod + MIN_W > BASE_W)
            divisor_d = MIN_DIV;
        else
            divisor_d = BASE_DIV - prod[24:0];

        div_rst_n_d = (state_d == ST_RUN);

        // Gating on the next state keeps the first cycle after leaving RUN tick-free
        s1_d   = div_clk;
        s2_d   = s1_q;
        s3_d   = s2_q;
        tick_d = s2_q && !s3_q && (state_d == ST_RUN);
    end

    assign divisor   = divisor_q;
    assign div_rst_n = div_rst_n_q;
    assign tick      = tick_q;
    assign level     = level_q;
    assign state     = state_q;

endmodule
